mmio_input_port: RTL and testbench

//   Memory-mapped input side of the board I/O bus; complements the seven-segment write path.

---
 rtl/io_pkg.sv | 19 +
 rtl/button_debouncer.sv | 72 +++++++
 rtl/mmio_input_port.sv | 78 +++++++
 tb/tb_mmio_input_port.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared board I/O bus definitions: MMIO addresses,
// button debouncer states and status register bit positions.
package io_pkg;

  localparam logic [31:0] IO_SEG_ADDR       = 32'hFFFF_FFF0;
  localparam logic [31:0] IO_SW_DATA_ADDR   = 32'hFFFF_FFF4;
  localparam logic [31:0] IO_SW_STATUS_ADDR = 32'hFFFF_FFF8;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;

endpackage

// File: rtl/button_debouncer.sv
// Confirmation button synchroniser and debounce FSM.
// Emits a single-cycle capture pulse per accepted press.
module button_debouncer
  import io_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic capture
);

  localparam logic [19:0] LAST = DEBOUNCE_CYCLES - 20'd1;

  logic [1:0] syncQ;
  logic       btn;
  btn_state_t state;
  btn_state_t nextState;
  logic [19:0] count;
  logic [19:0] nextCount;

  assign btn = syncQ[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncQ <= 2'b00;
      state <= IDLE;
      count <= '0;
    end else begin
      syncQ <= {syncQ[0], btnRaw};
      state <= nextState;
      count <= nextCount;
    end
  end

  // counter only runs while a level change is being qualified
  always_comb begin
    nextState = state;
    nextCount = '0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn) nextState = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn) begin
          nextState = IDLE;
        end else if (count == LAST) begin
          nextState = HELD;
          capture   = 1'b1;
        end else begin
          nextCount = count + 20'd1;
        end
      end
      HELD: begin
        if (!btn) nextState = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn) begin
          nextState = HELD;
        end else if (count == LAST) begin
          nextState = IDLE;
        end else begin
          nextCount = count + 20'd1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped switch input port: debounced capture, data/status regs.
// Define SWITCH_SIGN_EXT_EN to sign-extend the switch word on data loads.
module mmio_input_port
  import io_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000,
  parameter logic [31:0] DATA_ADDR       = IO_SW_DATA_ADDR,
  parameter logic [31:0] STATUS_ADDR     = IO_SW_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switchInput,
  input  logic        confirmation,
  input  logic [31:0] address,
  input  logic        readEn,
  output logic [31:0] readData,
  output logic        dataValid
);

  logic        capture;
  logic [15:0] dataReg;
  logic        overflow;
  logic        dataHit;
  logic        statHit;
  logic [31:0] dataWord;
  logic [31:0] statusWord;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDeb (
    .clk    (clk),
    .rst    (rst),
    .btnRaw (confirmation),
    .capture(capture)
  );

  assign dataHit = readEn && (address == DATA_ADDR);
  assign statHit = readEn && (address == STATUS_ADDR);

  always_comb begin
`ifdef SWITCH_SIGN_EXT_EN
    dataWord = {{16{dataReg[15]}}, dataReg};
`else
    dataWord = {16'b0, dataReg};
`endif
    statusWord = '0;
    statusWord[STAT_VALID] = dataValid;
    statusWord[STAT_OVF]   = overflow;
  end

  // a capture landing on a data read is not a lost value
  always_ff @(posedge clk) begin
    if (!rst) begin
      dataReg   <= '0;
      dataValid <= 1'b0;
      overflow  <= 1'b0;
      readData  <= '0;
    end else begin
      if (capture) dataReg <= switchInput;
      if (capture) begin
        dataValid <= 1'b1;
      end else if (dataHit) begin
        dataValid <= 1'b0;
      end
      if (statHit) begin
        overflow <= capture & dataValid;
      end else if (capture && dataValid && !dataHit) begin
        overflow <= 1'b1;
      end
      if (dataHit) begin
        readData <= dataWord;
      end else if (statHit) begin
        readData <= statusWord;
      end
    end
  end

endmodule

// File: tb/tb_mmio_input_port.sv
// Bench for mmio_input_port: vector table, corner sequences,
// and random traffic against a level-run reference model.
module tb_mmio_input_port;

  localparam int D = 4;
  localparam logic [31:0] A_DATA  = 32'hFFFF_FFF4;
  localparam logic [31:0] A_STAT  = 32'hFFFF_FFF8;
  localparam logic [31:0] A_OTHER = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switchInput;
  logic        confirmation;
  logic [31:0] address;
  logic        readEn;
  logic [31:0] readData;
  logic        dataValid;

  int total = 0;
  int bad = 0;

  mmio_input_port #(
    .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .switchInput (switchInput),
    .confirmation(confirmation),
    .address     (address),
    .readEn      (readEn),
    .readData    (readData),
    .dataValid   (dataValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [15:0] v);
`ifdef SWITCH_SIGN_EXT_EN
    return {{16{v[15]}}, v};
`else
    return {16'b0, v};
`endif
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [15:0] sw, input int hold);
    switchInput  = sw;
    confirmation = 1'b1;
    repeat (hold) tick();
    confirmation = 1'b0;
    repeat (D + 6) tick();
  endtask

  task automatic doRead(input logic [31:0] a);
    address = a;
    readEn  = 1'b1;
    tick();
    readEn  = 1'b0;
    address = '0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // rdKind: 0 none, 1 data, 2 status, 3 unmapped
  typedef struct {
    logic        doPress;
    logic [15:0] sw;
    int          hold;
    int          rdKind;
    logic [31:0] expRd;
    logic        expValid;
  } vec_t;

  vec_t vecs[10];

  // reference model: debounce judged from runs of stable synced level
  logic        mH1, mH2, mArmed;
  int          mHi, mLo;
  logic [15:0] mData;
  logic        mValid, mOvf;
  logic [31:0] mRd;

  function automatic void modelReset();
    mH1 = 0; mH2 = 0; mArmed = 1; mHi = 0; mLo = 0;
    mData = 0; mValid = 0; mOvf = 0; mRd = 0;
  endfunction

  function automatic void modelStep(input logic raw,
                                    input logic [15:0] sw,
                                    input logic rd,
                                    input logic [31:0] a);
    logic seen, cap, dRd, sRd, oV, oO;
    logic [15:0] oD;
    seen = mH2; mH2 = mH1; mH1 = raw;
    cap = 0;
    if (seen) begin
      mHi++; mLo = 0;
      if (mArmed && mHi == D + 1) begin
        cap = 1; mArmed = 0;
      end
    end else begin
      mLo++; mHi = 0;
      if (mLo >= D + 1) mArmed = 1;
    end
    dRd = rd && a == A_DATA;
    sRd = rd && a == A_STAT;
    oV = mValid; oO = mOvf; oD = mData;
    if (cap) begin
      mData = sw; mValid = 1;
      if (oV && !dRd) mOvf = 1;
    end
    if (dRd) begin
      mRd = ext(oD);
      if (!cap) mValid = 0;
    end
    if (sRd) begin
      mRd = {30'b0, oO, oV};
      mOvf = cap ? oV : 1'b0;
    end
  endfunction

  initial begin
    logic seenCap;
    logic lvl;
    int r;
    rst = 1'b0;
    switchInput = 16'hA5A5;
    confirmation = 1'b0;
    address = '0;
    readEn = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check("reset_readData", readData, 32'h0);
    check("reset_valid", {31'b0, dataValid}, 32'h0);

    vecs[0] = '{1'b0, 16'h0000, 0, 2, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 16'h1234, 10, 1, 32'h0000_1234, 1'b0};
    vecs[2] = '{1'b1, 16'h00FF, 2, 2, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 16'h5555, 10, 0, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 16'hAAAA, 10, 2, 32'h3, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 0, 2, 32'h1, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 0, 1, 32'h0000_AAAA, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 0, 3, 32'h0000_AAAA, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 0, 2, 32'h0, 1'b0};
    vecs[9] = '{1'b1, 16'h8001, 10, 1, ext(16'h8001), 1'b0};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].doPress) press(vecs[i].sw, vecs[i].hold);
      case (vecs[i].rdKind)
        1: doRead(A_DATA);
        2: doRead(A_STAT);
        3: doRead(A_OTHER);
        default: ;
      endcase
      if (vecs[i].rdKind != 0)
        check($sformatf("vec%0d_rd", i), readData, vecs[i].expRd);
      check($sformatf("vec%0d_valid", i),
            {31'b0, dataValid}, {31'b0, vecs[i].expValid});
    end

    // bouncing button every cycle
    switchInput = 16'h7777;
    for (int i = 0; i < 20; i++) begin
      confirmation = ~confirmation;
      tick();
      check("bounce_valid", {31'b0, dataValid}, 32'h0);
    end
    confirmation = 1'b0;
    repeat (D + 6) tick();
    doRead(A_STAT);
    check("bounce_status", readData, 32'h0);

    // capture lands on the same edge as a data read
    switchInput = 16'h4321;
    confirmation = 1'b1;
    repeat (D + 2) tick();
    doRead(A_DATA);
    check("coinc_rd_old", readData, ext(16'h8001));
    check("coinc_valid", {31'b0, dataValid}, 32'h1);
    confirmation = 1'b0;
    repeat (D + 6) tick();
    doRead(A_STAT);
    check("coinc_status", readData, 32'h1);
    doRead(A_DATA);
    check("coinc_rd_new", readData, 32'h0000_4321);

    // reset mid-debounce
    switchInput = 16'h0F0F;
    confirmation = 1'b1;
    repeat (4) tick();
    doReset();
    check("midrst_valid", {31'b0, dataValid}, 32'h0);
    check("midrst_rd", readData, 32'h0);
    for (int i = 0; i < D; i++) begin
      tick();
      check("midrst_early", {31'b0, dataValid}, 32'h0);
    end
    seenCap = 1'b0;
    for (int i = 0; i < 20 && !seenCap; i++) begin
      tick();
      seenCap = dataValid;
    end
    check("midrst_capture", {31'b0, seenCap}, 32'h1);
    confirmation = 1'b0;
    repeat (D + 6) tick();
    doRead(A_DATA);
    check("midrst_data", readData, 32'h0000_0F0F);

    // random traffic against the model
    doReset();
    modelReset();
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 11);
      if (lvl ? (r < 2) : (r < 1)) lvl = ~lvl;
      confirmation = lvl;
      switchInput = 16'($urandom);
      readEn = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: address = A_DATA;
        1: address = A_STAT;
        2: address = A_OTHER;
        default: address = $urandom;
      endcase
      tick();
      modelStep(confirmation, switchInput, readEn, address);
      check("rand_rd", readData, mRd);
      check("rand_valid", {31'b0, dataValid}, {31'b0, mValid});
    end
    readEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
